bcd_conv_seq: RTL and testbench
===============================

Name: bcd_conv_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly downstream of the divider and consumes one result word (quotient or remainder) plus the divider's error flag.
- Produces packed decimal digits for the display driver, with a start/ready handshake matching the divider's.

Parameters:
- bits, 8, width of the binary input word.
- digits, 3, number of BCD output digits. Must satisfy 10^digits > 2^bits - 1; the width is not checked in RTL.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous active-low reset; reset=0 clears all state immediately.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  bits  binary value to convert; sampled on the accepted start edge.
- err_in  input  1  divider error flag; sampled on the accepted start edge.
- bcd  output  4*digits  packed BCD result; digit 0 (ones) is in bcd[3:0].
- err  output  1  registered error flag belonging to the current bcd value.
- ready  output  1  one-cycle pulse: bcd/err have just been updated.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; bcd=0, err=0, ready=0, busy=0; scratch and counter cleared. Reset mid-conversion aborts it; no ready pulse follows.
- States are IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k and err_in=0: load shift register with bin, clear BCD scratch, set counter=bits, go to SHIFT, busy=1.
  - start=1 and err_in=1: go to DONE with error pending, busy=1.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - Every scratch nibble >=5 gets +3 (combinational, before the shift).
  - Shift {scratch, shreg} left by 1; the MSB of shreg enters scratch bit 0.
  - Decrement counter; when the counter reaches 0 after this shift, go to DONE.
  - Exactly `bits` SHIFT edges occur: k+1 .. k+bits.
- DONE, one edge:
  - bcd <= scratch and err <= 0; or, on the error path, every digit <= 4'hE and err <= 1.
  - ready <= 1, busy <= 0, go to IDLE.
- Latency:
  - Normal path: start sampled at edge k; bcd/err/ready update at edge k+bits+1, so ready is high in the cycle after that edge.
  - Error path: update at edge k+2.
- ready is high for exactly one cycle. It is the registered output of the DONE transition and clears on the next edge.
- busy is 0 in the ready cycle, so a start asserted during the ready cycle is accepted (back-to-back).
- start while busy=1 is ignored; no queueing.
- bin and err_in may change freely after acceptance; only the values sampled at the accepted edge matter.
- bcd and err hold their last values until the next DONE; they are never cleared except by reset.
- Arithmetic:
  - The add-3 is a 4-bit unsigned add with no carry out; for inputs 5..9 the result is 8..12.
  - The scratch width is 4*digits; no overflow is possible when the digits constraint holds.
- Counter width is clog2(bits+1) bits.

Decomposition:
- Shared constants include, next to the divider's: state encodings (IDLE, SHIFT, DONE) and BCD_ERR_DIGIT = 4'hE.
- One natural sub-module: bcd_digit_adj, a combinational 4-bit "if >=5 then +3" corrector, instantiated `digits` times via generate.
- FSM, counter and registers live in the top module.

Test Plan:
- Reset, then bin=8'd0, err_in=0, start pulse at edge k -> ready at k+9, bcd=12'h000, err=0, busy high edges k+1..k+8.
- bin=8'd255 -> bcd=12'h255, ready exactly 1 cycle wide. bin=8'd109 -> bcd=12'h109. bin=8'd99 -> bcd=12'h099.
- err_in=1, bin=8'd7, start -> ready at k+2, bcd=12'hEEE, err=1. A following normal conversion of 8'd42 -> bcd=12'h042, err=0.
- Start bin=8'd200, re-pulse start with bin=8'd13 at k+4 -> result 12'h200 only; a start in the ready cycle with 8'd13 -> second result 12'h013, 9 cycles later.
- Start 8'd150, drive reset=0 at k+5 mid-cycle -> outputs 0 immediately (asynchronously); reset released -> no ready pulse; a fresh conversion works normally.
- Exhaustive sweep 0..255 back-to-back -> every bcd matches the decimal reference model; exactly 256 ready pulses.

Source files
------------

// File: rtl/bcd_conv_seq_pkg.sv
// Shared constants for the binary-to-BCD converter stage.
package bcd_conv_seq_pkg;

    // Converter FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    // Digit shown on every position when the divider flagged an error
    localparam logic [3:0] BCD_ERR_DIGIT = 4'hE;

    // Double-dabble correction: nibbles at or above the threshold get the add
    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble nibble corrector: values 5..9 become 8..12
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_conv_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] digit_adj
);

    // 4-bit add with no carry out; inputs >= 5 never exceed 9 in normal use
    assign digit_adj = (digit >= BCD_ADJ_THRESHOLD) ? (digit + BCD_ADJ_ADD) : digit;

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Accepts a result word and error flag from the divider with a
// start/ready handshake and hands packed digits to the display driver.
module bcd_conv_seq
    import bcd_conv_seq_pkg::*;
#(
    parameter int bits   = 8,
    parameter int digits = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [bits-1:0]       bin,
    input  logic                  err_in,
    output logic [4*digits-1:0]   bcd,
    output logic                  err,
    output logic                  ready,
    output logic                  busy
);

    localparam int CW = $clog2(bits + 1);
    localparam int SW = 4 * digits;

    bcd_state_t          state_reg;
    logic [bits-1:0]     shreg_reg;
    logic [SW-1:0]       scratch_reg;
    logic [CW-1:0]       cnt_reg;
    logic                err_pend_reg;
    logic [SW-1:0]       bcd_reg;
    logic                err_reg;
    logic                ready_reg;
    logic                busy_reg;

    logic [SW-1:0]       scratch_adj;
    logic [SW+bits-1:0]  cat_shift;

    // Per-digit add-3 correction ahead of each shift
    generate
        for (genvar gi = 0; gi < digits; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit     (scratch_reg[gi*4 +: 4]),
                .digit_adj (scratch_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Corrected scratch and shift register moved left as one word
    always_comb begin
        cat_shift = {scratch_adj, shreg_reg} << 1;
    end

    // FSM, counter, scratch and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            shreg_reg    <= '0;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            err_pend_reg <= 1'b0;
            bcd_reg      <= '0;
            err_reg      <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (err_in) begin
                            // Error word: no conversion, but DONE holds one
                            // extra edge so the result lands at k+2
                            err_pend_reg <= 1'b1;
                            cnt_reg      <= CW'(1);
                            state_reg    <= ST_DONE;
                        end else begin
                            err_pend_reg <= 1'b0;
                            shreg_reg    <= bin;
                            scratch_reg  <= '0;
                            cnt_reg      <= CW'(bits);
                            state_reg    <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    scratch_reg <= cat_shift[SW+bits-1:bits];
                    shreg_reg   <= cat_shift[bits-1:0];
                    cnt_reg     <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end else begin
                        if (err_pend_reg) begin
                            bcd_reg <= {digits{BCD_ERR_DIGIT}};
                            err_reg <= 1'b1;
                        end else begin
                            bcd_reg <= scratch_reg;
                            err_reg <= 1'b0;
                        end
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd   = bcd_reg;
    assign err   = err_reg;
    assign ready = ready_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Scoreboard bench for bcd_conv_seq: stimulus pushes expected results,
// a monitor pops and compares on every ready pulse.
module tb_bcd_conv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin = 8'd0;
    logic        err_in = 1'b0;
    logic [11:0] bcd;
    logic        err;
    logic        ready;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int ready_cnt = 0;

    typedef struct {
        logic [11:0] bcd;
        logic        err;
        int          edge_no;
    } exp_t;

    exp_t sb_q[$];

    bcd_conv_seq #(.bits(8), .digits(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin    (bin),
        .err_in (err_in),
        .bcd    (bcd),
        .err    (err),
        .ready  (ready),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [11:0] dec_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: compares every ready pulse against the scoreboard head
    initial begin
        exp_t e;
        bit   prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ready) check("ready_width", ready, 0);
            if (ready === 1'b1) begin
                ready_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("result bcd=%03h err=%0b at edge %0d (expected %03h/%0b at %0d)",
                             bcd, err, cyc, e.bcd, e.err, e.edge_no);
                    check("bcd", bcd, e.bcd);
                    check("err", err, e.err);
                    check("latency_edge", cyc, e.edge_no);
                    check("busy_in_ready", busy, 0);
                end
            end
            prev_ready = (ready === 1'b1);
        end
    end

    // Drive one accepted start and queue the expected result
    task automatic issue(input logic [7:0] v, input logic e,
                         input logic [11:0] exp_bcd, input logic exp_err);
        exp_t x;
        start  = 1'b1;
        bin    = v;
        err_in = e;
        @(posedge clk);
        #1;
        x.bcd     = exp_bcd;
        x.err     = exp_err;
        x.edge_no = cyc + (e ? 2 : 9);
        sb_q.push_back(x);
        check("busy_after_accept", busy, 1);
        start  = 1'b0;
        bin    = 8'($urandom);
        err_in = 1'($urandom);
    endtask

    // Bounded wait for ready; returns at the negedge where ready is high
    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < budget);
        if (ready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    initial begin
        int base;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", bcd, 0);
        check("rst_err", err, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);

        // Zero input, busy held through the shift phase
        issue(8'd0, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("busy_during_shift", busy, 1);
        end
        wait_ready(20);

        // Directed values, back-to-back starts in the ready cycle
        @(negedge clk);
        issue(8'd255, 1'b0, 12'h255, 1'b0);
        wait_ready(20);
        issue(8'd109, 1'b0, 12'h109, 1'b0);
        wait_ready(20);
        issue(8'd99, 1'b0, 12'h099, 1'b0);
        wait_ready(20);

        // Error path then a normal conversion
        @(negedge clk);
        issue(8'd7, 1'b1, 12'hEEE, 1'b1);
        wait_ready(10);
        @(negedge clk);
        issue(8'd42, 1'b0, 12'h042, 1'b0);
        wait_ready(20);

        // Start while busy is ignored; start in ready cycle is accepted
        @(negedge clk);
        issue(8'd200, 1'b0, 12'h200, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin   = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(20);
        issue(8'd13, 1'b0, 12'h013, 1'b0);
        wait_ready(20);

        // Asynchronous reset mid-conversion aborts without a ready pulse
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd150;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_bcd", bcd, 0);
        check("async_rst_err", err, 0);
        check("async_rst_ready", ready, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("no_ready_after_abort", ready_cnt, 8);
        issue(8'd150, 1'b0, 12'h150, 1'b0);
        wait_ready(20);

        // Sweep every input value back-to-back against the decimal model
        @(negedge clk);
        base = ready_cnt;
        for (int v = 0; v < 256; v++) begin
            issue(8'(v), 1'b0, dec_ref(v), 1'b0);
            wait_ready(20);
        end
        repeat (3) @(negedge clk);
        check("sweep_ready_count", ready_cnt - base, 256);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time limit
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
